// File: rtl/jtframe_lfbuf_ddr_bank.sv
// Two-bank line RAM: the bank select is the address MSB. One data write port, one
// fill port (writes a constant) and one asynchronous read port.
module jtframe_lfbuf_ddr_bank #(
    parameter int DW = 16,
    parameter int HW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [HW:0]   waddr,
    input  logic [DW-1:0] wdata,
    input  logic          fill,
    input  logic [HW:0]   faddr,
    input  logic [DW-1:0] fdata,
    input  logic [HW:0]   raddr,
    output logic [DW-1:0] rdata
);
    localparam int unsigned BANKS = 2;
    localparam int unsigned DEPTH = BANKS << HW;

    logic [DW-1:0] mem [DEPTH];

    // Callers keep the two ports on opposite banks, so their order never matters.
    always_ff @(posedge clk) begin
        if (fill) mem[faddr] <= fdata;
        if (we)   mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/jtframe_lfbuf_ddr_line.sv
// Pixel-side line buffers for the DDR frame buffer: game-line hand-off to the
// controller and one-line-delayed scan playback.
module jtframe_lfbuf_ddr_line #(
    parameter int DW = 16,
    parameter int VW = 8,
    parameter int HW = 9
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          pxl_cen,
    input  logic          vs,
    input  logic          lvbl,
    input  logic          lhbl,
    input  logic [HW-1:0] hdump,
    input  logic [HW-1:0] ln_addr,
    input  logic [DW-1:0] ln_data,
    input  logic          ln_we,
    input  logic          ln_hs,
    output logic          ln_done,
    output logic [VW-1:0] ln_v,
    output logic          frame,
    input  logic [HW-1:0] fb_addr,
    output logic [DW-1:0] fb_din,
    input  logic          fb_clr,
    input  logic          fb_done,
    input  logic [DW-1:0] fb_dout,
    input  logic [HW-1:0] rd_addr,
    input  logic          scr_we,
    input  logic          scr_ok,
    output logic [DW-1:0] pxl,
    output logic          ovr
);
    localparam logic [DW-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_FLUSH
    } busy_t;

    busy_t         st, st_nx;
    logic          busy;
    logic          vs_l, vs_rise;
    logic          lhbl_l;
    logic          wbank, sbank;
    logic [VW-1:0] cnt;
    logic [DW-1:0] sdout;
    logic          active;

    assign vs_rise = vs & ~vs_l;
    assign busy    = st != ST_IDLE;
    assign active  = lhbl & lvbl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= ST_IDLE;
        else     st <= st_nx;
    end

    // Busy ends only once fb_done has dropped and the clear sweep is over.
    always_comb begin
        st_nx = st;
        case (st)
            ST_BUSY:  if (fb_done) st_nx = ST_FLUSH;
            ST_FLUSH: if (!fb_done && !fb_clr) st_nx = ST_IDLE;
            default:  st_nx = ST_IDLE;
        endcase
        if (ln_hs) st_nx = ST_BUSY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_l    <= 1'b0;
            lhbl_l  <= 1'b0;
            wbank   <= 1'b0;
            sbank   <= 1'b0;
            ln_done <= 1'b0;
            ln_v    <= '0;
            cnt     <= '0;
            frame   <= 1'b0;
            ovr     <= 1'b0;
            pxl     <= '0;
        end else begin
            vs_l    <= vs;
            ln_done <= ln_hs;
            if (ln_hs) begin
                wbank <= ~wbank;
                ln_v  <= cnt;
                cnt   <= cnt + 1'b1;
            end
            // A frame start in the same cycle as ln_hs still wins the counter.
            if (vs_rise) begin
                frame <= ~frame;
                cnt   <= '0;
                ovr   <= 1'b0;
            end
            if (ln_hs && busy) ovr <= 1'b1;
            if (pxl_cen) begin
                lhbl_l <= lhbl;
                if (lhbl_l && !lhbl && lvbl) sbank <= ~sbank;
                pxl <= active ? sdout : ZERO;
            end
        end
    end

    jtframe_lfbuf_ddr_bank #(.DW(DW), .HW(HW)) u_wbuf (
        .clk   ( clk               ),
        .we    ( ln_we             ),
        .waddr ( {wbank, ln_addr}  ),
        .wdata ( ln_data           ),
        .fill  ( fb_clr            ),
        .faddr ( {~wbank, fb_addr} ),
        .fdata ( ZERO              ),
        .raddr ( {~wbank, fb_addr} ),
        .rdata ( fb_din            )
    );

    jtframe_lfbuf_ddr_bank #(.DW(DW), .HW(HW)) u_sbuf (
        .clk   ( clk                  ),
        .we    ( scr_we & scr_ok      ),
        .waddr ( {sbank, rd_addr}     ),
        .wdata ( fb_dout              ),
        .fill  ( pxl_cen & active     ),
        .faddr ( {~sbank, hdump}      ),
        .fdata ( ZERO                 ),
        .raddr ( {~sbank, hdump}      ),
        .rdata ( sdout                )
    );
endmodule

// File: tb/tb_jtframe_lfbuf_ddr_line.sv
// Directed bench for jtframe_lfbuf_ddr_line with scoreboard queues for ln_v and pxl.
module tb_jtframe_lfbuf_ddr_line;
    localparam int DW = 16;
    localparam int VW = 8;
    localparam int HW = 9;

    logic          rst = 1'b1, clk = 1'b0, pxl_cen = 1'b0;
    logic          vs = 1'b0, lvbl = 1'b1, lhbl = 1'b1;
    logic [HW-1:0] hdump = '0, ln_addr = '0, fb_addr = '0, rd_addr = '0;
    logic [DW-1:0] ln_data = '0, fb_dout = '0;
    logic          ln_we = 1'b0, ln_hs = 1'b0, fb_clr = 1'b0, fb_done = 1'b0;
    logic          scr_we = 1'b0, scr_ok = 1'b0;
    logic          ln_done, frame, ovr;
    logic [VW-1:0] ln_v;
    logic [DW-1:0] fb_din, pxl;

    int vectors = 0;
    int fails   = 0;

    logic [VW-1:0] sb_lnv [$];
    logic [DW-1:0] sb_pxl [$];

    int m_cnt   = 0;
    bit m_frame = 1'b0;
    bit m_ovr   = 1'b0;
    bit m_busy  = 1'b0;

    always #5 clk = ~clk;

    jtframe_lfbuf_ddr_line #(.DW(DW), .VW(VW), .HW(HW)) dut (
        .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .vs(vs), .lvbl(lvbl), .lhbl(lhbl),
        .hdump(hdump), .ln_addr(ln_addr), .ln_data(ln_data), .ln_we(ln_we), .ln_hs(ln_hs),
        .ln_done(ln_done), .ln_v(ln_v), .frame(frame), .fb_addr(fb_addr), .fb_din(fb_din),
        .fb_clr(fb_clr), .fb_done(fb_done), .fb_dout(fb_dout), .rd_addr(rd_addr),
        .scr_we(scr_we), .scr_ok(scr_ok), .pxl(pxl), .ovr(ovr)
    );

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lnv(input string tag);
        logic [VW-1:0] e;
        if (sb_lnv.size() == 0) begin
            vectors++; fails++;
            $error("FAIL %s: got %0h expected <empty scoreboard>", tag, ln_v);
        end else begin
            e = sb_lnv.pop_front();
            chk(tag, 32'(ln_v), 32'(e));
        end
    endtask

    task automatic chk_pxl(input string tag);
        logic [DW-1:0] e;
        if (sb_pxl.size() == 0) begin
            vectors++; fails++;
            $error("FAIL %s: got %0h expected <empty scoreboard>", tag, pxl);
        end else begin
            e = sb_pxl.pop_front();
            chk(tag, 32'(pxl), 32'(e));
        end
    endtask

    task automatic finish_line();
        fb_done = 1'b1; tick();
        fb_done = 1'b0; tick();
        m_busy = 1'b0;
    endtask

    task automatic hs_pulse(input bit with_vs, input bit fin);
        ln_hs = 1'b1;
        if (with_vs) vs = 1'b1;
        sb_lnv.push_back(VW'(m_cnt));
        if (with_vs) begin
            m_frame = ~m_frame;
            m_ovr   = 1'b0;
            m_cnt   = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
        if (m_busy) m_ovr = 1'b1;
        m_busy = 1'b1;
        tick();
        ln_hs = 1'b0;
        chk("ln_done_hi", 32'(ln_done), 32'd1);
        chk_lnv("ln_v");
        chk("frame", 32'(frame), 32'(m_frame));
        chk("ovr", 32'(ovr), 32'(m_ovr));
        tick();
        chk("ln_done_lo", 32'(ln_done), 32'd0);
        if (fin) finish_line();
    endtask

    task automatic vs_pulse();
        vs = 1'b1; tick();
        vs = 1'b0; tick();
        m_frame = ~m_frame;
        m_cnt   = 0;
        m_ovr   = 1'b0;
        chk("vs_frame", 32'(frame), 32'(m_frame));
        chk("vs_ovr", 32'(ovr), 32'(m_ovr));
    endtask

    // mode 0: playback not compared, 1: fetched data expected, 2: black expected
    task automatic scan_line(input bit do_fetch, input bit conc, input int mode);
        lhbl = 1'b0;
        hdump = 9'h1f0;
        sb_pxl.push_back('0);
        tick();
        chk_pxl("pxl_blank");
        if (do_fetch && !conc) begin
            for (int a = 0; a < 64; a++) begin
                rd_addr = HW'(a);
                scr_we  = 1'b1;
                scr_ok  = 1'b0;
                fb_dout = 16'hdead;
                tick();
                scr_ok  = 1'b1;
                fb_dout = 16'h1000 + 16'(a);
                tick();
            end
            scr_we = 1'b0;
            scr_ok = 1'b0;
        end
        lhbl = 1'b1;
        for (int h = 0; h < 64; h++) begin
            hdump = HW'(h);
            if (conc) begin
                scr_we  = 1'b1;
                scr_ok  = 1'b1;
                rd_addr = HW'(h);
                fb_dout = 16'h1000 + 16'(h);
            end
            if (mode == 1) sb_pxl.push_back(16'h1000 + 16'(h));
            else if (mode == 2) sb_pxl.push_back('0);
            tick();
            if (mode != 0) chk_pxl(mode == 1 ? "pxl_data" : "pxl_black");
        end
        scr_we = 1'b0;
        scr_ok = 1'b0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_ln_done", 32'(ln_done), 32'd0);
        chk("rst_ln_v", 32'(ln_v), 32'd0);
        chk("rst_frame", 32'(frame), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_pxl", 32'(pxl), 32'd0);
        rst = 1'b0;
        tick();

        for (int x = 0; x < 512; x++) begin
            ln_we = 1'b1; ln_addr = HW'(x); ln_data = DW'(x);
            tick();
        end
        ln_we = 1'b0;
        hs_pulse(1'b0, 1'b0);
        fb_addr = 9'd5;   #1; chk("fb_din_5", 32'(fb_din), 32'd5);
        fb_addr = 9'd0;   #1; chk("fb_din_0", 32'(fb_din), 32'd0);
        fb_addr = 9'd511; #1; chk("fb_din_511", 32'(fb_din), 32'd511);

        fb_done = 1'b1; tick(); fb_done = 1'b0;
        for (int a = 0; a < 512; a++) begin
            fb_clr = 1'b1; fb_addr = HW'(a);
            tick();
        end
        fb_clr = 1'b0;
        tick();
        m_busy = 1'b0;

        hs_pulse(1'b0, 1'b1);
        hs_pulse(1'b0, 1'b1);
        for (int a = 0; a < 512; a++) begin
            fb_addr = HW'(a); #1;
            chk("fb_din_clr", 32'(fb_din), 32'd0);
        end

        vs_pulse();
        hs_pulse(1'b0, 1'b1);
        hs_pulse(1'b1, 1'b1);
        vs = 1'b0;
        tick();
        hs_pulse(1'b0, 1'b1);

        hs_pulse(1'b0, 1'b0);
        hs_pulse(1'b0, 1'b0);
        hs_pulse(1'b0, 1'b1);
        vs_pulse();

        pxl_cen = 1'b1;
        lhbl = 1'b1;
        tick();
        scan_line(1'b1, 1'b0, 0);
        scan_line(1'b0, 1'b0, 1);
        scan_line(1'b0, 1'b0, 2);
        scan_line(1'b1, 1'b0, 2);
        scan_line(1'b1, 1'b1, 1);
        scan_line(1'b0, 1'b0, 1);
        pxl_cen = 1'b0;
        hdump = '0;
        tick(); tick(); tick();
        chk("pxl_hold", 32'(pxl), 32'h103f);

        vs_pulse();
        hs_pulse(1'b0, 1'b0);
        hs_pulse(1'b0, 1'b0);
        scr_we = 1'b1; scr_ok = 1'b1; rd_addr = 9'd7; fb_dout = 16'h1234;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ln_done", 32'(ln_done), 32'd0);
        chk("mid_rst_ln_v", 32'(ln_v), 32'd0);
        chk("mid_rst_frame", 32'(frame), 32'd0);
        chk("mid_rst_ovr", 32'(ovr), 32'd0);
        chk("mid_rst_pxl", 32'(pxl), 32'd0);
        scr_we = 1'b0; scr_ok = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ovr", 32'(ovr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
